// File: rtl/neuron_state_shiftreg.sv
// neuron_state_shiftreg: multi-channel signed neuron-state history buffer with handshake, preload, freeze and fill tracking
module neuron_state_shiftreg #(
  parameter int W = 2,
  parameter int DEPTH = 20,
  parameter int CH = 1,
  parameter logic [W-1:0] RST_VAL = 2'b01,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic                  update_clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*W-1:0]       xin,
  input  logic                  load_en,
  input  logic [CH*DEPTH*W-1:0] load_data,
  input  logic                  freeze,
  input  logic                  err_clr,
  output logic [CH*DEPTH*W-1:0] xalt_packed,
  output logic [FW-1:0]         fill_cnt,
  output logic                  primed,
  output logic                  shift_strobe,
  output logic                  err_sticky
);
  typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;
  state_t state_q, state_d;
  logic [CH*DEPTH*W-1:0] slot_q, slot_d;
  logic [FW-1:0] fill_q, fill_d;
  logic primed_q, primed_d, strobe_q, strobe_d, err_q, err_d;
  logic accept, bad_in, bad_ld;
  function automatic logic illegal(input logic [W-1:0] v);
    return W == 2 && v == W'(2);
  endfunction
  function automatic logic [W-1:0] sanitise(input logic [W-1:0] v);
    return illegal(v) ? '1 : v;
  endfunction
  assign in_ready = !freeze && !load_en;
  assign accept = in_valid && in_ready;
  always_comb begin
    bad_in = 1'b0;
    bad_ld = 1'b0;
    for (int c = 0; c < CH; c++) bad_in = bad_in | illegal(xin[c*W +: W]);
    for (int i = 0; i < CH*DEPTH; i++) bad_ld = bad_ld | illegal(load_data[i*W +: W]);
    slot_d = slot_q;
    fill_d = fill_q;
    state_d = state_q;
    strobe_d = 1'b0;
    if (load_en) begin
      for (int i = 0; i < CH*DEPTH; i++) slot_d[i*W +: W] = sanitise(load_data[i*W +: W]);
      fill_d = FW'(DEPTH);
      strobe_d = 1'b1;
      state_d = state_q == HOLD ? HOLD : RUN;
    end else if (freeze) begin
      state_d = HOLD;
    end else begin
      if (accept) begin
        for (int c = 0; c < CH; c++) begin
          slot_d[c*DEPTH*W +: W] = sanitise(xin[c*W +: W]);
          for (int j = 1; j < DEPTH; j++) slot_d[(c*DEPTH+j)*W +: W] = slot_q[(c*DEPTH+j-1)*W +: W];
        end
        fill_d = fill_q == FW'(DEPTH) ? fill_q : fill_q + 1'b1;
        strobe_d = 1'b1;
      end
      state_d = fill_d == FW'(DEPTH) ? RUN : FILL;
    end
    primed_d = fill_d == FW'(DEPTH);
    err_d = (err_q && !err_clr) || (accept && bad_in) || (load_en && bad_ld);
  end
  always_ff @(posedge update_clk) begin
    if (rst) begin
      state_q <= FILL;
      slot_q <= {CH*DEPTH{RST_VAL}};
      fill_q <= '0;
      primed_q <= 1'b0;
      strobe_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      fill_q <= fill_d;
      primed_q <= primed_d;
      strobe_q <= strobe_d;
      err_q <= err_d;
    end
  end
  assign xalt_packed = slot_q;
  assign fill_cnt = fill_q;
  assign primed = primed_q;
  assign shift_strobe = strobe_q;
  assign err_sticky = err_q;
endmodule
